core_lsu_biu: RTL and testbench

Bus interface unit directly downstream of the LSU execute stage. Takes one LSU memory request (load or aligned store with byte mask), drives it onto the core's data-memory bus command/response channels, and returns read data or error to the LSU. One transaction is in flight at a time. A configurable timeout converts a hung bus into an error response.

---
 rtl/core_lsu_biu_pkg.sv | 24 ++
 rtl/gnrl_dffs.sv | 33 +++
 rtl/core_lsu_biu.sv | 145 ++++++++++++++
 tb/tb_core_lsu_biu.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_lsu_biu_pkg.sv
// Shared widths and helpers for the LSU bus interface unit.
// Core-wide defaults live here so every file sees the same macro values.
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_LSU_WMASK_WIDTH
`define CORE_LSU_WMASK_WIDTH 4
`endif
`ifndef CORE_BIU_TIMEOUT
`define CORE_BIU_TIMEOUT 255
`endif

package core_lsu_biu_pkg;
    localparam int XLEN    = `CORE_XLEN;
    localparam int WMASK_W = `CORE_LSU_WMASK_WIDTH;

    // Counter must hold 0..timeout; a disabled timeout still needs one bit.
    function automatic int biu_cnt_width(input int timeout);
        if (timeout <= 0)
            return 1;
        else
            return $clog2(timeout + 1);
    endfunction
endpackage

// File: rtl/gnrl_dffs.sv
// General flop library: plain reset flop and load-enabled reset flop.
module gnrl_dffr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            qout <= '0;
        else
            qout <= dnxt;
    end
endmodule

module gnrl_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            qout <= '0;
        else if (lden)
            qout <= dnxt;
    end
endmodule

// File: rtl/core_lsu_biu.sv
// LSU-to-data-bus bridge: one transaction in flight, timeout turns a hung bus
// into an error response and drains the late response afterwards.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for an LSU request
// CMD      | command presented on the bus, waiting for cmd_ready
// WAIT     | command accepted, waiting for the bus response (timed)
// RESP     | response presented to the LSU, waiting for lsu_rsp_ready
// DRAIN    | timed-out transaction still owed a response; swallow it
module core_lsu_biu
    import core_lsu_biu_pkg::*;
#(
    parameter int TIMEOUT = `CORE_BIU_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic               lsu_req_write,
    input  logic [XLEN-1:0]    lsu_req_addr,
    input  logic [XLEN-1:0]    lsu_req_wdata,
    input  logic [WMASK_W-1:0] lsu_req_wmask,
    output logic               lsu_rsp_valid,
    input  logic               lsu_rsp_ready,
    output logic [XLEN-1:0]    lsu_rsp_rdata,
    output logic               lsu_rsp_err,
    output logic               bus_cmd_valid,
    input  logic               bus_cmd_ready,
    output logic               bus_cmd_write,
    output logic [XLEN-1:0]    bus_cmd_addr,
    output logic [XLEN-1:0]    bus_cmd_wdata,
    output logic [WMASK_W-1:0] bus_cmd_wstrb,
    input  logic               bus_rsp_valid,
    output logic               bus_rsp_ready,
    input  logic [XLEN-1:0]    bus_rsp_rdata,
    input  logic               bus_rsp_err
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam int CW = biu_cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic               orphan_q;
    logic               orphan_d;
    logic               req_ld;
    logic               rsp_ld;
    logic               cnt_ld;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic [XLEN-1:0]    rsp_rdata_d;
    logic               rsp_err_d;
    logic [WMASK_W-1:0] req_wstrb;

    always_comb begin
        state_d     = state_q;
        orphan_d    = orphan_q;
        req_ld      = 1'b0;
        rsp_ld      = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        cnt_ld      = 1'b0;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (lsu_req_valid) begin
                    req_ld  = 1'b1;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (bus_cmd_ready) begin
                    cnt_ld  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response arriving on the limit cycle beats the timeout.
                if (bus_rsp_valid) begin
                    rsp_ld      = 1'b1;
                    rsp_err_d   = bus_rsp_err;
                    rsp_rdata_d = (!bus_cmd_write && !bus_rsp_err) ? bus_rsp_rdata : '0;
                    state_d     = ST_RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    rsp_ld    = 1'b1;
                    rsp_err_d = 1'b1;
                    orphan_d  = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_ld = (cnt_q != CNT_MAX);
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
            ST_RESP: begin
                if (lsu_rsp_ready)
                    state_d = orphan_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus_rsp_valid) begin
                    orphan_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_wstrb = lsu_req_write ? lsu_req_wmask : '0;

    gnrl_dffr #(.DW(3)) u_state (
        .clk(clk), .rst_n(rst_n), .dnxt(state_d), .qout(state_q)
    );
    gnrl_dffr #(.DW(1)) u_orphan (
        .clk(clk), .rst_n(rst_n), .dnxt(orphan_d), .qout(orphan_q)
    );
    gnrl_dfflr #(.DW(1 + 2 * XLEN + WMASK_W)) u_cmd (
        .clk(clk), .rst_n(rst_n), .lden(req_ld),
        .dnxt({lsu_req_write, lsu_req_addr, lsu_req_wdata, req_wstrb}),
        .qout({bus_cmd_write, bus_cmd_addr, bus_cmd_wdata, bus_cmd_wstrb})
    );
    gnrl_dfflr #(.DW(1 + XLEN)) u_rsp (
        .clk(clk), .rst_n(rst_n), .lden(rsp_ld),
        .dnxt({rsp_err_d, rsp_rdata_d}),
        .qout({lsu_rsp_err, lsu_rsp_rdata})
    );
    gnrl_dfflr #(.DW(CW)) u_cnt (
        .clk(clk), .rst_n(rst_n), .lden(cnt_ld), .dnxt(cnt_d), .qout(cnt_q)
    );

    assign lsu_req_ready = (state_q == ST_IDLE);
    assign bus_cmd_valid = (state_q == ST_CMD);
    assign lsu_rsp_valid = (state_q == ST_RESP);
    assign bus_rsp_ready = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
endmodule

// File: tb/tb_core_lsu_biu.sv
// Scoreboarded bench for core_lsu_biu built with a 4-cycle timeout.
module tb_core_lsu_biu;
    import core_lsu_biu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_req_write = 1'b0;
    logic [31:0] lsu_req_addr = '0;
    logic [31:0] lsu_req_wdata = '0;
    logic [3:0]  lsu_req_wmask = '0;
    logic        lsu_rsp_valid;
    logic        lsu_rsp_ready = 1'b0;
    logic [31:0] lsu_rsp_rdata;
    logic        lsu_rsp_err;
    logic        bus_cmd_valid;
    logic        bus_cmd_ready = 1'b0;
    logic        bus_cmd_write;
    logic [31:0] bus_cmd_addr;
    logic [31:0] bus_cmd_wdata;
    logic [3:0]  bus_cmd_wstrb;
    logic        bus_rsp_valid = 1'b0;
    logic        bus_rsp_ready;
    logic [31:0] bus_rsp_rdata = '0;
    logic        bus_rsp_err = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    core_lsu_biu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_write(lsu_req_write), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
        .bus_cmd_valid(bus_cmd_valid), .bus_cmd_ready(bus_cmd_ready),
        .bus_cmd_write(bus_cmd_write), .bus_cmd_addr(bus_cmd_addr),
        .bus_cmd_wdata(bus_cmd_wdata), .bus_cmd_wstrb(bus_cmd_wstrb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_ready(bus_rsp_ready),
        .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
    );

    // Drives one transaction; cmd_ok/hold_ok record stability and handshake
    // observations, lat counts cycles from request edge to lsu_rsp_valid.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, input int cmd_wait, input int rsp_wait,
                           input logic r_err, input logic [31:0] r_data, input int hold,
                           output int lat, output logic [31:0] o_rdata, output logic o_err,
                           output logic cmd_ok, output logic hold_ok, output logic to);
        logic [3:0] exp_strb;
        int cyc;
        exp_strb = wr ? wmask : 4'h0;
        cmd_ok = 1'b1; hold_ok = 1'b1; to = 1'b0; lat = 0; cyc = 0;
        o_rdata = '0; o_err = 1'b0;
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_write = wr; lsu_req_addr = addr;
        lsu_req_wdata = wdata; lsu_req_wmask = wmask;
        @(negedge clk); cyc = 1;
        lsu_req_valid = 1'b0; lsu_req_write = ~wr; lsu_req_addr = '1;
        lsu_req_wdata = ~wdata; lsu_req_wmask = '1;
        for (int i = 0; i <= cmd_wait; i++) begin
            if (bus_cmd_valid !== 1'b1 || bus_cmd_write !== wr || bus_cmd_addr !== addr ||
                bus_cmd_wdata !== wdata || bus_cmd_wstrb !== exp_strb)
                cmd_ok = 1'b0;
            bus_cmd_ready = (i == cmd_wait);
            @(negedge clk); cyc++;
        end
        bus_cmd_ready = 1'b0;
        for (int i = 0; i <= rsp_wait; i++) begin
            if (bus_rsp_ready !== 1'b1 || lsu_rsp_valid !== 1'b0 || bus_cmd_valid !== 1'b0)
                cmd_ok = 1'b0;
            bus_rsp_valid = (i == rsp_wait); bus_rsp_err = r_err; bus_rsp_rdata = r_data;
            @(negedge clk); cyc++;
        end
        bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rsp_rdata = '0;
        while (lsu_rsp_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk); cyc++;
        end
        if (lsu_rsp_valid !== 1'b1) begin
            to = 1'b1;
            return;
        end
        lat = cyc; o_rdata = lsu_rsp_rdata; o_err = lsu_rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== o_rdata || lsu_rsp_err !== o_err)
                hold_ok = 1'b0;
        end
        lsu_rsp_ready = 1'b1;
        @(negedge clk);
        lsu_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (lsu_req_ready !== 1'b1 || lsu_rsp_valid !== 1'b0 || bus_cmd_valid !== 1'b0 ||
            bus_rsp_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req_rdy=%b rsp_vld=%b cmd_vld=%b rsp_rdy=%b, want 1 0 0 0",
                     lsu_req_ready, lsu_rsp_valid, bus_cmd_valid, bus_rsp_ready);
        end
        checks++;
        if ({bus_cmd_write, bus_cmd_addr, bus_cmd_wdata, bus_cmd_wstrb, lsu_rsp_rdata, lsu_rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h wstrb=%h rdata=%h err=%b, want all 0",
                     bus_cmd_addr, bus_cmd_wdata, bus_cmd_wstrb, lsu_rsp_rdata, lsu_rsp_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_zero_wait();
        int lat; logic [31:0] rd; logic er, cok, hok, to; exp_t e;
        sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
        run_txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, 0, 0, 1'b0, 32'hDEAD_BEEF, 0, lat, rd, er, cok, hok, to);
        e = sb.pop_front();
        checks++;
        if (to || lat !== 3) begin errors++; $display("FAIL load_latency: got %0d (timeout=%b) want 3", lat, to); end
        checks++;
        if (rd !== e.rdata || er !== e.err) begin errors++; $display("FAIL load_data: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
        checks++;
        if (!cok) begin errors++; $display("FAIL load_cmd: got cmd fields/handshake wrong, want addr 80000010 wstrb 0"); end
    endtask

    task automatic test_store_backpressure();
        int lat; logic [31:0] rd; logic er, cok, hok, to; exp_t e;
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        run_txn(1'b1, 32'h8000_0004, 32'h0000_AB00, 4'b0010, 4, 1, 1'b0, 32'hFFFF_FFFF, 0, lat, rd, er, cok, hok, to);
        e = sb.pop_front();
        checks++;
        if (!cok) begin errors++; $display("FAIL store_cmd_stable: got unstable or wrong cmd, want wstrb 0010 held 4 cycles"); end
        checks++;
        if (to || rd !== e.rdata || er !== e.err) begin errors++; $display("FAIL store_rsp: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL store_latency: got %0d want 8", lat); end
    endtask

    task automatic test_bus_error();
        int lat; logic [31:0] rd; logic er, cok, hok, to; exp_t e;
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        run_txn(1'b0, 32'h8000_0100, 32'h0, 4'h0, 1, 0, 1'b1, 32'h1234_5678, 0, lat, rd, er, cok, hok, to);
        e = sb.pop_front();
        checks++;
        if (to || rd !== e.rdata || er !== e.err) begin errors++; $display("FAIL bus_error: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    endtask

    task automatic test_timeout();
        int waits; logic drain_ok; exp_t e;
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 32'h8000_0020;
        @(negedge clk);
        lsu_req_valid = 1'b0; bus_cmd_ready = 1'b1;
        @(negedge clk);
        bus_cmd_ready = 1'b0;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            if (lsu_rsp_valid === 1'b1) break;
            if (bus_rsp_ready === 1'b1) waits++;
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if (waits !== 4) begin errors++; $display("FAIL timeout_wait_cycles: got %0d want 4", waits); end
        checks++;
        if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== e.rdata || lsu_rsp_err !== e.err) begin
            errors++;
            $display("FAIL timeout_rsp: got vld=%b %h/%b want 1 %h/%b", lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err, e.rdata, e.err);
        end
        lsu_rsp_ready = 1'b1;
        @(negedge clk);
        lsu_rsp_ready = 1'b0;
        drain_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (lsu_req_ready !== 1'b0 || bus_rsp_ready !== 1'b1 || lsu_rsp_valid !== 1'b0) drain_ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!drain_ok) begin errors++; $display("FAIL timeout_drain: got req_ready/bus_rsp_ready wrong, want 0/1 while draining"); end
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
        checks++;
        if (lsu_req_ready !== 1'b1 || lsu_rsp_valid !== 1'b0 || bus_rsp_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_drain_exit: got req_rdy=%b rsp_vld=%b want 1 0", lsu_req_ready, lsu_rsp_valid);
        end
    endtask

    task automatic test_race();
        int lat; logic [31:0] rd; logic er, cok, hok, to; exp_t e;
        sb.push_back('{rdata: 32'h5A5A_0F0F, err: 1'b0});
        run_txn(1'b0, 32'h8000_0040, 32'h0, 4'h0, 0, 3, 1'b0, 32'h5A5A_0F0F, 0, lat, rd, er, cok, hok, to);
        e = sb.pop_front();
        checks++;
        if (to || !cok || rd !== e.rdata || er !== e.err) begin
            errors++; $display("FAIL race_rsp: got %h/%b ok=%b want %h/%b", rd, er, cok, e.rdata, e.err);
        end
        checks++;
        if (lsu_req_ready !== 1'b1 || bus_rsp_ready !== 1'b0) begin
            errors++; $display("FAIL race_no_drain: got req_rdy=%b rsp_rdy=%b want 1 0", lsu_req_ready, bus_rsp_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er, cok, hok, to; exp_t e;
        logic [31:0] data;
        for (int k = 0; k < 3; k++) begin
            data = $urandom;
            sb.push_back('{rdata: data, err: 1'b0});
            run_txn(1'b0, 32'h9000_0000 + 32'(k * 4), 32'h0, 4'h0, k, k, 1'b0, data, 0, lat, rd, er, cok, hok, to);
            e = sb.pop_front();
            checks++;
            if (to || !cok || rd !== e.rdata || er !== e.err || lsu_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: got %h/%b req_rdy=%b want %h/%b req_rdy=1", k, rd, er, lsu_req_ready, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_resp_hold();
        int lat; logic [31:0] rd; logic er, cok, hok, to; exp_t e;
        sb.push_back('{rdata: 32'h0BAD_CAFE, err: 1'b0});
        run_txn(1'b0, 32'h8000_0080, 32'h0, 4'h0, 0, 1, 1'b0, 32'h0BAD_CAFE, 10, lat, rd, er, cok, hok, to);
        e = sb.pop_front();
        checks++;
        if (to || !hok || rd !== e.rdata || er !== e.err) begin
            errors++; $display("FAIL resp_hold: got %h/%b stable=%b want %h/%b stable=1", rd, er, hok, e.rdata, e.err);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 32'h8000_0200;
        @(negedge clk);
        lsu_req_valid = 1'b0; bus_cmd_ready = 1'b1;
        @(negedge clk);
        bus_cmd_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (lsu_req_ready !== 1'b1 || bus_rsp_ready !== 1'b0 || bus_cmd_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait: got req_rdy=%b rsp_rdy=%b cmd_vld=%b rsp_vld=%b want 1 0 0 0",
                     lsu_req_ready, bus_rsp_ready, bus_cmd_valid, lsu_rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0300;
        @(negedge clk);
        lsu_req_valid = 1'b0; bus_cmd_ready = 1'b1;
        @(negedge clk);
        bus_cmd_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
        @(negedge clk);
        checks++;
        if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL resp_before_reset: got vld=%b %h want 1 cafef00d", lsu_rsp_valid, lsu_rsp_rdata);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (lsu_rsp_valid !== 1'b0 || lsu_rsp_rdata !== 32'h0 || lsu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_resp: got vld=%b rdata=%h req_rdy=%b want 0 0 1", lsu_rsp_valid, lsu_rsp_rdata, lsu_req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_after_reset();
        int lat; logic [31:0] rd; logic er, cok, hok, to; exp_t e;
        sb.push_back('{rdata: 32'h7777_1111, err: 1'b0});
        run_txn(1'b0, 32'h8000_0400, 32'h0, 4'h0, 0, 0, 1'b0, 32'h7777_1111, 0, lat, rd, er, cok, hok, to);
        e = sb.pop_front();
        checks++;
        if (to || lat !== 3 || rd !== e.rdata || er !== e.err) begin
            errors++; $display("FAIL after_reset: got %h/%b lat=%0d want %h/%b lat=3", rd, er, lat, e.rdata, e.err);
        end
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_backpressure();
        test_bus_error();
        test_timeout();
        test_race();
        test_back_to_back();
        test_resp_hold();
        test_reset_mid();
        test_after_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got no completion by 20000 time units, want finish");
        $fatal(1, "watchdog");
    end
endmodule
